// File: rtl/gdsart_word_writer_pkg.sv
// gdsart_writer_pkg: shared widths, default depth and writer FSM states
package gdsart_writer_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam int DEF_AW = 3;
    typedef enum logic [1:0] {LO, HI, FULL} state_e;
endpackage

// File: rtl/gdsart_word_writer_if.sv
// gdsart_word_writer_if: byte-in handshake, read port and status of the word writer
interface gdsart_word_writer_if import gdsart_writer_pkg::*; #(parameter int AW = DEF_AW);
    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic [AW-1:0]     rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic [AW-1:0]     wr_ptr;
    logic              word_done;
    logic              full;
    logic [WORD_W-1:0] csum;
    modport master (output in_valid, in_data, rd_addr,
                    input in_ready, rd_data, wr_ptr, word_done, full, csum);
    modport slave (input in_valid, in_data, rd_addr,
                   output in_ready, rd_data, wr_ptr, word_done, full, csum);
endinterface

// File: rtl/gdsart_word_writer_regfile.sv
// gdsart_regfile: 2**AW x 16 store, one sync write port, one combinational read port
module gdsart_regfile import gdsart_writer_pkg::*; #(
    parameter int AW = DEF_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);
    logic [WORD_W-1:0] mem_q [2**AW];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
        else if (we_i)
            mem_q[waddr_i] <= wdata_i;
    // same-cycle read of the address being written still sees the old word
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/gdsart_word_writer.sv
// gdsart_word_writer: packs a low/high byte stream into words at an auto-incrementing pointer.
// Define WRITER_CHECKSUM_EN to build the running XOR checksum; otherwise csum reads 0.
module gdsart_word_writer import gdsart_writer_pkg::*; #(
    parameter int AW   = DEF_AW,
    parameter bit WRAP = 1'b1
) (
    input logic clk,
    input logic rst_n,
    input logic clr,
    gdsart_word_writer_if.slave bus
);
    state_e            state_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [BYTE_W-1:0] lo_q;
    logic              word_done_q, full_q;
    logic              xfer, commit, last;
    logic [WORD_W-1:0] word;
    assign bus.in_ready = (state_q != FULL);
    assign xfer   = bus.in_valid && bus.in_ready;
    assign commit = xfer && (state_q == HI) && !clr;
    assign last   = &wr_ptr_q;
    assign word   = {bus.in_data, lo_q};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= LO;
            wr_ptr_q    <= '0;
            lo_q        <= '0;
            word_done_q <= 1'b0;
            full_q      <= 1'b0;
        end else if (clr) begin
            state_q     <= LO;
            wr_ptr_q    <= '0;
            word_done_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            word_done_q <= commit;
            if (xfer && state_q == LO) begin
                lo_q    <= bus.in_data;
                state_q <= HI;
            end else if (commit) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                state_q  <= (last && !WRAP) ? FULL : LO;
                if (last) full_q <= 1'b1;
            end
        end
`ifdef WRITER_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            csum_q <= '0;
        else if (clr)
            csum_q <= '0;
        else if (commit)
            csum_q <= csum_q ^ word;
    assign bus.csum = csum_q;
`else
    assign bus.csum = '0;
`endif
    assign bus.wr_ptr    = wr_ptr_q;
    assign bus.word_done = word_done_q;
    assign bus.full      = full_q;
    gdsart_regfile #(.AW(AW)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (commit),
        .waddr_i (wr_ptr_q),
        .wdata_i (word),
        .raddr_i (bus.rd_addr),
        .rdata_o (bus.rd_data)
    );
endmodule

// File: tb/tb_gdsart_word_writer.sv
// tb_gdsart_word_writer: scoreboard bench for a WRAP=1 instance (0) and a WRAP=0 instance (1)
module tb_gdsart_word_writer;
    typedef struct {int b; logic [2:0] addr; logic [15:0] word;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] vld, clr, rdy, dn, fl;
    logic [7:0] dat[2];
    logic [2:0] ra[2], wp[2];
    logic [15:0] rdat[2], cs[2];
    logic [15:0] mem_m[2][8];
    logic [2:0] ptr_m[2];
    logic [15:0] csum_m[2];
    exp_t exp_q[$];
    exp_t e;
    int passed = 0, total = 0;

    gdsart_word_writer_if #(.AW(3)) bw ();
    gdsart_word_writer_if #(.AW(3)) bn ();
    assign bw.in_valid = vld[0];
    assign bw.in_data  = dat[0];
    assign bw.rd_addr  = ra[0];
    assign bn.in_valid = vld[1];
    assign bn.in_data  = dat[1];
    assign bn.rd_addr  = ra[1];
    assign rdy  = {bn.in_ready, bw.in_ready};
    assign dn   = {bn.word_done, bw.word_done};
    assign fl   = {bn.full, bw.full};
    assign rdat[0] = bw.rd_data;
    assign rdat[1] = bn.rd_data;
    assign wp[0] = bw.wr_ptr;
    assign wp[1] = bn.wr_ptr;
    assign cs[0] = bw.csum;
    assign cs[1] = bn.csum;

    gdsart_word_writer #(.AW(3), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]), .bus(bw));
    gdsart_word_writer #(.AW(3), .WRAP(1'b0)) u_nowrap (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]), .bus(bn));

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 8; i++) mem_m[b][i] = '0;
            ptr_m[b] = '0;
            csum_m[b] = '0;
        end
    endtask

    task automatic send_byte(input int b, input logic [7:0] d);
        vld[b] = 1'b1;
        dat[b] = d;
        idle(1);
        vld[b] = 1'b0;
    endtask

    task automatic push_word(input int b, input logic [15:0] w);
        exp_q.push_back('{b, ptr_m[b], w});
        mem_m[b][ptr_m[b]] = w;
        ptr_m[b] = ptr_m[b] + 3'd1;
`ifdef WRITER_CHECKSUM_EN
        csum_m[b] = csum_m[b] ^ w;
`endif
    endtask

    task automatic send_word(input int b, input logic [15:0] w);
        push_word(b, w);
        send_byte(b, w[7:0]);
        send_byte(b, w[15:8]);
    endtask

    task automatic do_clr(input int b);
        clr[b] = 1'b1;
        idle(1);
        clr[b] = 1'b0;
        ptr_m[b] = '0;
        csum_m[b] = '0;
    endtask

    task automatic test_reset();
        for (int b = 0; b < 2; b++) begin
            total++; if (rdy[b] !== 1'b1) $display("FAIL reset_ready[%0d] got %0b want 1", b, rdy[b]); else passed++;
            total++; if (wp[b] !== 3'd0) $display("FAIL reset_ptr[%0d] got %0d want 0", b, wp[b]); else passed++;
            total++; if (dn[b] !== 1'b0 || fl[b] !== 1'b0) $display("FAIL reset_flags[%0d] done=%0b full=%0b want 0 0", b, dn[b], fl[b]); else passed++;
            total++; if (cs[b] !== 16'h0) $display("FAIL reset_csum[%0d] got %h want 0000", b, cs[b]); else passed++;
        end
        for (int i = 0; i < 8; i++) begin
            ra[0] = 3'(i);
            #1;
            total++; if (rdat[0] !== 16'h0) $display("FAIL reset_mem[%0d] got %h want 0000", i, rdat[0]); else passed++;
        end
    endtask

    task automatic test_first_word();
        send_word(0, 16'h1234);
        e = exp_q.pop_front();
        ra[0] = e.addr;
        #1;
        total++; if (dn[0] !== 1'b1) $display("FAIL first_done got %0b want 1", dn[0]); else passed++;
        total++; if (rdat[0] !== e.word) $display("FAIL first_word got %h want %h", rdat[0], e.word); else passed++;
        total++; if (wp[0] !== 3'd1) $display("FAIL first_ptr got %0d want 1", wp[0]); else passed++;
        total++; if (cs[0] !== csum_m[0]) $display("FAIL first_csum got %h want %h", cs[0], csum_m[0]); else passed++;
        idle(1);
        total++; if (dn[0] !== 1'b0) $display("FAIL first_done_pulse got %0b want 0", dn[0]); else passed++;
    endtask

    task automatic test_wrap();
        do_clr(0);
        for (int i = 1; i <= 9; i++) begin
            send_word(0, (i == 9) ? 16'hBBAA : 16'(i));
            e = exp_q.pop_front();
            ra[0] = e.addr;
            #1;
            total++; if (dn[0] !== 1'b1 || rdat[0] !== e.word) $display("FAIL wrap_word%0d done=%0b data=%h want 1 %h", i, dn[0], rdat[0], e.word); else passed++;
            if (i == 8) begin
                total++; if (fl[0] !== 1'b1 || wp[0] !== 3'd0 || rdy[0] !== 1'b1) $display("FAIL wrap_state full=%0b ptr=%0d ready=%0b want 1 0 1", fl[0], wp[0], rdy[0]); else passed++;
            end
        end
        total++; if (e.addr !== 3'd0 || fl[0] !== 1'b1 || wp[0] !== 3'd1) $display("FAIL wrap_overwrite addr=%0d full=%0b ptr=%0d want 0 1 1", e.addr, fl[0], wp[0]); else passed++;
    endtask

    task automatic test_no_wrap();
        for (int i = 1; i <= 8; i++) begin
            send_word(1, 16'(i));
            e = exp_q.pop_front();
            ra[1] = e.addr;
            #1;
            total++; if (dn[1] !== 1'b1 || rdat[1] !== e.word) $display("FAIL nowrap_word%0d done=%0b data=%h want 1 %h", i, dn[1], rdat[1], e.word); else passed++;
        end
        total++; if (rdy[1] !== 1'b0 || fl[1] !== 1'b1 || wp[1] !== 3'd0) $display("FAIL nowrap_full ready=%0b full=%0b ptr=%0d want 0 1 0", rdy[1], fl[1], wp[1]); else passed++;
        send_byte(1, 8'hEE);
        send_byte(1, 8'hFF);
        total++; if (dn[1] !== 1'b0 || rdy[1] !== 1'b0) $display("FAIL nowrap_ignore done=%0b ready=%0b want 0 0", dn[1], rdy[1]); else passed++;
        for (int i = 0; i < 8; i++) begin
            ra[1] = 3'(i);
            #1;
            total++; if (rdat[1] !== mem_m[1][i]) $display("FAIL nowrap_mem[%0d] got %h want %h", i, rdat[1], mem_m[1][i]); else passed++;
        end
        do_clr(1);
        total++; if (rdy[1] !== 1'b1 || wp[1] !== 3'd0 || fl[1] !== 1'b0) $display("FAIL nowrap_clr ready=%0b ptr=%0d full=%0b want 1 0 0", rdy[1], wp[1], fl[1]); else passed++;
    endtask

    task automatic test_clr_drop();
        do_clr(0);
        send_byte(0, 8'h55);
        vld[0] = 1'b1;
        dat[0] = 8'h66;
        do_clr(0);
        vld[0] = 1'b0;
        total++; if (wp[0] !== 3'd0 || dn[0] !== 1'b0 || fl[0] !== 1'b0) $display("FAIL clr_drop ptr=%0d done=%0b full=%0b want 0 0 0", wp[0], dn[0], fl[0]); else passed++;
        send_word(0, 16'h8877);
        e = exp_q.pop_front();
        ra[0] = e.addr;
        #1;
        total++; if (e.addr !== 3'd0 || rdat[0] !== 16'h8877 || dn[0] !== 1'b1) $display("FAIL clr_next addr=%0d data=%h done=%0b want 0 8877 1", e.addr, rdat[0], dn[0]); else passed++;
    endtask

    task automatic test_gapped();
        logic [15:0] w[3] = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
        for (int i = 0; i < 3; i++) begin
            send_byte(0, w[i][7:0]);
            idle(2);
            ra[0] = ptr_m[0];
            vld[0] = 1'b1;
            dat[0] = w[i][15:8];
            #1;
            total++; if (rdat[0] !== mem_m[0][ptr_m[0]]) $display("FAIL gap_old%0d got %h want %h", i, rdat[0], mem_m[0][ptr_m[0]]); else passed++;
            push_word(0, w[i]);
            idle(1);
            vld[0] = 1'b0;
            e = exp_q.pop_front();
            total++; if (rdat[0] !== e.word || dn[0] !== 1'b1) $display("FAIL gap_new%0d data=%h done=%0b want %h 1", i, rdat[0], dn[0], e.word); else passed++;
            idle(1);
        end
        for (int i = 0; i < 8; i++) begin
            ra[0] = 3'(i);
            #1;
            total++; if (rdat[0] !== mem_m[0][i]) $display("FAIL gap_sweep[%0d] got %h want %h", i, rdat[0], mem_m[0][i]); else passed++;
        end
    endtask

    task automatic test_csum();
        do_clr(0);
        send_word(0, 16'h1234);
        e = exp_q.pop_front();
        send_word(0, 16'h00FF);
        e = exp_q.pop_front();
        #1;
        total++; if (cs[0] !== csum_m[0]) $display("FAIL csum_model got %h want %h", cs[0], csum_m[0]); else passed++;
`ifdef WRITER_CHECKSUM_EN
        total++; if (cs[0] !== 16'h12CB) $display("FAIL csum_value got %h want 12cb", cs[0]); else passed++;
`else
        total++; if (cs[0] !== 16'h0000) $display("FAIL csum_tied got %h want 0000", cs[0]); else passed++;
`endif
        do_clr(0);
        total++; if (cs[0] !== 16'h0) $display("FAIL csum_clr got %h want 0000", cs[0]); else passed++;
    endtask

    task automatic test_reset_mid_word();
        send_byte(0, 8'h99);
        rst_n = 1'b0;
        #2;
        ra[0] = 3'd0;
        #1;
        total++; if (rdat[0] !== 16'h0 || wp[0] !== 3'd0 || fl[0] !== 1'b0) $display("FAIL rst_mid data=%h ptr=%0d full=%0b want 0000 0 0", rdat[0], wp[0], fl[0]); else passed++;
        rst_n = 1'b1;
        model_reset();
        idle(1);
        send_word(0, 16'h2211);
        e = exp_q.pop_front();
        ra[0] = e.addr;
        #1;
        total++; if (rdat[0] !== 16'h2211 || e.addr !== 3'd0) $display("FAIL rst_mid_next data=%h addr=%0d want 2211 0", rdat[0], e.addr); else passed++;
    endtask

    initial begin
        vld = '0;
        clr = '0;
        dat[0] = '0; dat[1] = '0;
        ra[0] = '0; ra[1] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        test_reset();
        idle(1);
        test_first_word();
        test_wrap();
        test_no_wrap();
        test_clr_drop();
        test_gapped();
        test_csum();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gdsart_word_writer.md
Name: gdsart_word_writer

Overview:
- Writable counterpart of the 8x16 art ROM: accepts a byte stream with a valid/ready handshake and packs byte pairs into 16-bit words.
- Writes words into an 8-entry register store at an auto-incrementing pointer.
- Exposes a zero-latency combinational read port with the same shape as the ROM lookup (3-bit address in, 16-bit word out), so the top level can swap ROM for RAM.
- Sits between the ui_in/uio_in pins and the uo_out/uio_out output mux.

Parameters:
- AW, 3, address width; depth = 2**AW words.
- WRAP, 1, 1 = pointer wraps to 0 after the last entry and writing continues; 0 = block stops in FULL after the last entry.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear: pointer, FSM, flags and checksum; storage untouched
- in_valid  input  1  byte offered
- in_data  input  8  byte; low byte of a word first, then high byte
- in_ready  output  1  block can accept a byte
- rd_addr  input  AW  read address
- rd_data  output  16  combinational read of mem[rd_addr]
- wr_ptr  output  AW  address the next completed word will be written to
- word_done  output  1  one-cycle pulse, the cycle after a word is committed
- full  output  1  sticky; every entry written since reset/clr
- csum  output  16  XOR of committed words (see Optional Feature)

Behaviour:
- Reset (rst_n low, async):
  - state=LO, wr_ptr=0, low-byte latch=0, word_done=0, full=0, csum=0.
  - All mem entries=16'h0000.
- Transfer occurs on a rising edge with in_valid && in_ready. in_data is ignored otherwise.
- FSM states: LO, HI, FULL.
  - LO: on transfer, latch in_data as the low byte -> HI.
  - HI: on transfer, mem[wr_ptr] <= {in_data, low_latch} on that same edge; wr_ptr <= wr_ptr+1 (mod 2**AW); word_done=1 next cycle.
    - Not the last entry: -> LO.
    - Last entry (wr_ptr == 2**AW-1): full <= 1. WRAP=1 -> LO with wr_ptr=0. WRAP=0 -> FULL with wr_ptr=0.
  - FULL: in_ready=0; leave only via clr or reset.
- in_ready = (state != FULL). It is combinational from state only, never from in_valid.
- Read port:
  - rd_data is combinational from mem.
  - A write becomes visible on the cycle after its commit edge.
  - Read of the address being written on the same cycle returns the old word.
- clr has priority over a simultaneous transfer. The byte is dropped, state=LO, wr_ptr=0, full=0, word_done=0, csum=0.
- A half-received word (state HI) is discarded by clr or reset; mem is unchanged.
- With WRAP=1, full stays 1 after wrapping until clr. Subsequent words overwrite from address 0.
- Reset mid-word: the latch is lost; the next byte after release is treated as a low byte.

Optional Feature:
- Macro WRITER_CHECKSUM_EN.
- Defined: csum <= csum ^ committed_word on every commit edge; cleared by reset/clr.
- Undefined: csum is tied to 16'h0000, no checksum flops are synthesised, and the port remains present.

Decomposition:
- Package gdsart_writer_pkg contains:
  - state enum {LO, HI, FULL};
  - constants BYTE_W=8, WORD_W=16;
  - default AW=3.
- One natural sub-module, gdsart_regfile: 2**AW x 16 storage with async reset, one synchronous write port (we, waddr, wdata) and one combinational read port.
- The FSM, pointer, flags and checksum stay in gdsart_word_writer.

Test Plan:
- Reset then bytes 34,12 with valid held -> mem[0]=16'h1234 on the next cycle; word_done pulses once; wr_ptr=1; rd_addr=0 reads 16'h1234.
- 16 bytes forming words 16'h0001..16'h0008, WRAP=1 -> full=1, wr_ptr=0, in_ready=1. A 17th/18th byte pair AA,BB overwrites mem[0] with 16'hBBAA.
- Same 16 bytes with WRAP=0 -> state FULL, in_ready=0, full=1. Further valid bytes are ignored and mem is unchanged; clr returns in_ready=1, wr_ptr=0, full=0.
- Send low byte 55, assert clr with valid byte 66 on the same edge -> 66 is dropped and state is LO. Next pair 77,88 writes 16'h8877 at address 0.
- Gapped valid (valid low between and within pairs) plus a rd_addr sweep -> words assemble correctly; reading the address under write on the commit cycle shows the old value, then the new value the next cycle.
- WRITER_CHECKSUM_EN defined, words 16'h1234 and 16'h00FF -> csum=16'h12CB; clr -> csum=0. Macro undefined -> csum stays 0.
